// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the RV32I instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] NopInstr       = 32'h0000_0013;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry (pc, instr) holding register used when decode back-pressures a response.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NopInstr;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, keeps one imem request in flight and registers
// (pc, instr, pc+4) for decode, with stall back-pressure and redirect squashing.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_next_pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    logic         drop_q, drop_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_instr_q, out_instr_d;

    logic         skid_load, skid_unload, skid_flush, skid_valid;
    logic [31:0]  skid_pc, skid_instr;
    logic         req_valid, accept, consume;

    assign req_valid = (state_q == StReq) && rst_ni;
    assign accept    = req_valid && imem_req_ready_i;
    assign consume   = out_valid_q && !stall_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        if (consume) out_valid_d = 1'b0;
        if (accept) rsp_pc_d = word_align(pc_q);

        if (redirect_valid_i) begin
            pc_d        = word_align(redirect_pc_i);
            out_valid_d = 1'b0;
            skid_flush  = 1'b0 | 1'b1;
            drop_d      = 1'b0;
            // Anything still owed by memory belongs to the old path and must be squashed.
            if ((state_q == StWait && !imem_rsp_valid_i) || accept) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end else begin
                state_d = StReq;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    if (accept) begin
                        pc_d    = word_align(pc_q) + 32'd4;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = StReq;
                        end else if (!out_valid_q || consume) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = rsp_pc_q;
                            out_instr_d = imem_rsp_data_i;
                            state_d     = StReq;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = StHold;
                        end
                    end
                end
                StHold: begin
                    if (consume) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = skid_pc;
                        out_instr_d = skid_instr;
                        skid_unload = 1'b1;
                        state_d     = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StReq;
            pc_q        <= word_align(RESET_PC);
            rsp_pc_q    <= 32'h0;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= NopInstr;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (skid_flush),
        .pc_i     (rsp_pc_q),
        .instr_i  (imem_rsp_data_i),
        .valid_o  (skid_valid),
        .pc_o     (skid_pc),
        .instr_o  (skid_instr)
    );

    assign imem_req_valid_o = req_valid;
    assign imem_addr_o      = word_align(pc_q);
    assign if_valid_o       = out_valid_q;
    assign if_pc_o          = out_pc_q;
    assign if_instr_o       = out_instr_q;
    assign if_next_pc_o     = out_pc_q + 32'd4;

    // skid_valid is implied by StHold; kept observable for debug only.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle memory model and an in-order scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] ResetPc = 32'h0000_0100;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk, rst_n, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, if_next_pc;

    int errors = 0;
    int checks = 0;

    item_t       sb[$];
    logic [31:0] exp_pc;
    int          gen;
    logic        mem_pend, mem_hold;
    logic [31:0] mem_addr;
    int          mem_gen;

    logic        s_req_valid, s_if_valid;
    logic [31:0] s_addr, s_if_pc, s_if_instr, s_if_next_pc;

    fetch_stage #(.RESET_PC(ResetPc)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_addr_o      (imem_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .if_valid_o       (if_valid),
        .if_pc_o          (if_pc),
        .if_instr_o       (if_instr),
        .if_next_pc_o     (if_next_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_pc   = ResetPc;
        gen      = gen + 1;
        mem_pend = 1'b0;
        mem_hold = 1'b0;
        mem_addr = 32'h0;
        mem_gen  = 0;
    endtask

    // One clock: drive at negedge, sample and score, then advance the memory model.
    task automatic cycle(input logic rdy, input logic stl, input logic rdv,
                         input logic [31:0] rpc);
        logic        acc, rsp;
        int          acc_gen;
        @(negedge clk);
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        rsp            = mem_pend && !mem_hold;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(mem_addr) : 32'hDEAD_BEEF;
        #1;
        s_req_valid  = imem_req_valid;
        s_addr       = imem_addr;
        s_if_valid   = if_valid;
        s_if_pc      = if_pc;
        s_if_instr   = if_instr;
        s_if_next_pc = if_next_pc;

        chk1("if_valid_vs_scoreboard", s_if_valid, sb.size() != 0);
        if (s_if_valid && sb.size() != 0) begin
            chk32("if_pc", s_if_pc, sb[0].pc);
            chk32("if_instr", s_if_instr, sb[0].instr);
            chk32("if_next_pc", s_if_next_pc, sb[0].pc + 32'd4);
        end
        if (s_req_valid) chk32("imem_addr", s_addr, exp_pc);

        acc     = s_req_valid && rdy;
        acc_gen = gen;
        if (s_if_valid && !stl && !rdv && sb.size() != 0) void'(sb.pop_front());
        if (rsp && mem_gen == gen && !rdv) sb.push_back('{pc: mem_addr, instr: instr_of(mem_addr)});
        if (rdv) begin
            sb.delete();
            gen    = gen + 1;
            exp_pc = rpc & 32'hFFFF_FFFC;
        end else if (acc) begin
            exp_pc = exp_pc + 32'd4;
        end

        @(posedge clk);
        if (acc) begin
            mem_pend = 1'b1;
            mem_addr = s_addr;
            mem_gen  = acc_gen;
        end else if (rsp) begin
            mem_pend = 1'b0;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        gen            = 0;
        model_reset();

        // Reset values
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk1("rst_req_valid", s_req_valid, 1'b0);
        chk1("rst_if_valid", s_if_valid, 1'b0);
        chk32("rst_if_pc", s_if_pc, 32'h0);
        chk32("rst_if_instr", s_if_instr, Nop);
        chk32("rst_if_next_pc", s_if_next_pc, 32'h4);
        #2 rst_n = 1'b1;

        // Streaming with ready high, then ready low for 3 cycles
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk1("first_req_valid", s_req_valid, 1'b1);
        chk32("first_req_addr", s_addr, 32'h100);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            chk1("ready_low_req_valid", s_req_valid, 1'b1);
            chk32("ready_low_addr", s_addr, 32'h104);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk32("third_req_addr", s_addr, 32'h108);
        chk32("stream_if_pc", s_if_pc, 32'h104);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall while a response arrives: skid fills, requests stop
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk1("hold_no_request", s_req_valid, 1'b0);
        chk32("hold_if_pc", s_if_pc, 32'h108);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk32("skid_to_out_pc", s_if_pc, 32'h10C);
        chk1("after_skid_req_valid", s_req_valid, 1'b1);
        chk32("after_skid_addr", s_addr, 32'h110);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect while a response is pending
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        mem_hold = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 32'h200);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk1("redirect_if_valid_clear", s_if_valid, 1'b0);
        chk1("redirect_wait_no_req", s_req_valid, 1'b0);
        mem_hold = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk32("redirect_target_addr", s_addr, 32'h200);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Unaligned redirect under stall clears if_valid
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk32("redirect_delivered_pc", s_if_pc, 32'h200);
        chk1("redirect_delivered_valid", s_if_valid, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h203);
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk1("stall_redirect_if_valid", s_if_valid, 1'b0);
        chk32("unaligned_redirect_addr", s_addr, 32'h200);

        // PC wrap from 0xFFFF_FFFC to 0
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk32("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("wrap_next_addr", s_addr, 32'h0);
        chk32("wrap_if_pc", s_if_pc, 32'hFFFF_FFFC);
        chk32("wrap_if_next_pc", s_if_next_pc, 32'h0);

        // Asynchronous reset while a response is pending
        mem_hold = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk1("pre_reset_if_valid", s_if_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1("async_rst_if_valid", if_valid, 1'b0);
        chk32("async_rst_if_pc", if_pc, 32'h0);
        chk32("async_rst_if_instr", if_instr, Nop);
        chk1("async_rst_req_valid", imem_req_valid, 1'b0);
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk32("post_reset_addr", s_addr, ResetPc);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk32("post_reset_stream_pc", s_if_pc, 32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
